clk_div_ctrl: RTL and testbench

//  Reconfiguration controller for the ClkDiv block. Arbitrates ratio-change

---
 rtl/clk_div_ctrl_pkg.sv | 21 ++
 rtl/clk_div_ctrl_if.sv | 35 +++
 rtl/clk_div_rr_arb.sv | 43 ++++
 rtl/clk_div_ctrl.sv | 149 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg
//   Shared definitions for the ClkDiv reconfiguration controller:
//   FSM state encoding, client index constants and the default ratio width.
//   No ports.
package clk_div_ctrl_pkg;

    localparam int DEF_RATIO_W = 8;

    // Client indices; also used directly as bit positions in the ack vector.
    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_SETTLE,
        ST_ACK
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if
//   Bundle between the two ratio-change clients, the controller and ClkDiv.
//   Signals:
//     req0/req1       client change request, level, held until its ack
//     ratio0/ratio1   requested divide ratio, stable while req is high
//     ack0/ack1       1-cycle completion pulse per client
//     clk_en          to ClkDiv clock enable
//     div_ratio       to ClkDiv divide ratio
//     busy            controller not idle
//     owner           client of the current or most recent grant
//   Modports: master = client/observer side, slave = controller side.
interface clk_div_ctrl_if #(
    parameter int RATIO_W = clk_div_ctrl_pkg::DEF_RATIO_W
);
    logic               req0;
    logic [RATIO_W-1:0] ratio0;
    logic               ack0;
    logic               req1;
    logic [RATIO_W-1:0] ratio1;
    logic               ack1;
    logic               clk_en;
    logic [RATIO_W-1:0] div_ratio;
    logic               busy;
    logic               owner;

    modport master (
        output req0, ratio0, req1, ratio1,
        input  ack0, ack1, clk_en, div_ratio, busy, owner
    );

    modport slave (
        input  req0, ratio0, req1, ratio1,
        output ack0, ack1, clk_en, div_ratio, busy, owner
    );
endinterface

// File: rtl/clk_div_rr_arb.sv
// clk_div_rr_arb
//   Two-way round-robin arbiter. Grant is combinational from req and the
//   last-granted pointer; the pointer moves only when the caller takes the
//   grant (advance).
//   Ports:
//     clk, rst    clock, async active-high reset
//     req[1:0]    request per client
//     advance     caller accepted the current grant this cycle
//     grant_idx   index of the granted client
//     grant_vld   at least one request present
module clk_div_rr_arb
    import clk_div_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx,
    output logic       grant_vld
);

    logic last;

    always_comb begin
        grant_vld = |req;
        grant_idx = CLIENT0;
        if (req[0] && req[1]) begin
            grant_idx = ~last;
        end else if (req[1]) begin
            grant_idx = CLIENT1;
        end
    end

    // Reset to "client 1 was last" so client 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= CLIENT1;
        end else if (advance && grant_vld) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Reconfiguration controller for ClkDiv. Arbitrates ratio-change requests
//   from two clients, then: gate the divider (DRAIN), load the new ratio
//   (LOAD), re-enable and wait SETTLE_MULT*ratio cycles (SETTLE), pulse the
//   requester's ack (ACK). A request for the ratio already in use skips
//   straight to ACK. All outputs are registered.
//   Ports:
//     clk   reference clock shared with ClkDiv
//     rst   async active-high reset
//     bus   clk_div_ctrl_if.slave (requests in; acks, clk_en, div_ratio,
//           busy, owner out)
//   GUARD_CYC-1 must fit in the settle counter width.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int RATIO_W       = DEF_RATIO_W,
    parameter int GUARD_CYC     = 4,
    parameter int SETTLE_MULT   = 2,
    parameter int DEFAULT_RATIO = 1
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);

    // Wide enough for SETTLE_MULT * (2^RATIO_W - 1) without overflow.
    localparam int CNT_W = RATIO_W + $clog2(SETTLE_MULT) + 1;
    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [RATIO_W-1:0] RST_RATIO  = RATIO_W'(DEFAULT_RATIO);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RATIO_W-1:0] lat_ratio, lat_ratio_n;
    logic               owner_q, owner_n;
    logic               clk_en_q, clk_en_n;
    logic [RATIO_W-1:0] div_ratio_q, div_ratio_n;
    logic [1:0]         ack_q, ack_n;
    logic               busy_q, busy_n;

    logic               grant_idx, grant_vld, advance;
    logic [RATIO_W-1:0] req_ratio, req_ratio_clamped;
    logic [CNT_W-1:0]   settle_last;

    clk_div_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({bus.req1, bus.req0}),
        .advance   (advance),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign req_ratio         = (grant_idx == CLIENT1) ? bus.ratio1 : bus.ratio0;
    assign req_ratio_clamped = (req_ratio == '0) ? RATIO_W'(1) : req_ratio;

    // Counters load "length-1" and finish on zero.
    assign settle_last = CNT_W'(SETTLE_MULT) * CNT_W'(lat_ratio) - CNT_W'(1);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_ratio_n = lat_ratio;
        owner_n     = owner_q;
        clk_en_n    = clk_en_q;
        div_ratio_n = div_ratio_q;
        ack_n       = 2'b00;
        advance     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    advance     = 1'b1;
                    owner_n     = grant_idx;
                    lat_ratio_n = req_ratio_clamped;
                    if (req_ratio_clamped == div_ratio_q) begin
                        state_n          = ST_ACK;
                        ack_n[grant_idx] = 1'b1;
                    end else begin
                        state_n  = ST_DRAIN;
                        clk_en_n = 1'b0;
                        cnt_n    = GUARD_LAST;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_n = ST_LOAD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                // clk_en stays low during this cycle; the new ratio and the
                // re-enable both become visible on the first SETTLE cycle.
                div_ratio_n = lat_ratio;
                clk_en_n    = 1'b1;
                cnt_n       = settle_last;
                state_n     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_n        = ST_ACK;
                    ack_n[owner_q] = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_ACK: begin
                // No arbitration here: the owner may still hold req this cycle.
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_ratio   <= RST_RATIO;
            owner_q     <= CLIENT0;
            clk_en_q    <= 1'b1;
            div_ratio_q <= RST_RATIO;
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lat_ratio   <= lat_ratio_n;
            owner_q     <= owner_n;
            clk_en_q    <= clk_en_n;
            div_ratio_q <= div_ratio_n;
            ack_q       <= ack_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.clk_en    = clk_en_q;
    assign bus.div_ratio = div_ratio_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
//   Directed bench for clk_div_ctrl (RATIO_W=8, GUARD_CYC=4, SETTLE_MULT=2,
//   DEFAULT_RATIO=1). Stimulus pushes the hand-computed ack (client, cycle,
//   ratio) into a scoreboard; a negedge monitor pops and compares on every ack.
module tb_clk_div_ctrl;
    import clk_div_ctrl_pkg::*;

    localparam int RW = 8;

    typedef struct {
        bit cl;
        int cyc;
        int ratio;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   en_low_seen = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    clk_div_ctrl_if #(.RATIO_W(RW)) bus ();

    clk_div_ctrl #(
        .RATIO_W       (RW),
        .GUARD_CYC     (4),
        .SETTLE_MULT   (2),
        .DEFAULT_RATIO (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input bit cl, input int c, input int ratio);
        exp_t e;
        e.cl = cl; e.cyc = c; e.ratio = ratio;
        sb.push_back(e);
    endtask

    task automatic drive(input bit cl, input bit r, input int ratio);
        if (cl) begin bus.req1 = r; bus.ratio1 = RW'(ratio); end
        else    begin bus.req0 = r; bus.ratio0 = RW'(ratio); end
    endtask

    // Client behaviour: wait (bounded) for own ack, then release req.
    task automatic wait_ack(input bit cl, input int budget);
        int  n = 0;
        bit  hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (!bus.clk_en) en_low_seen = 1'b1;
            hit = cl ? bus.ack1 : bus.ack0;
        end
        if (!hit) check(cl ? "ack1_timeout" : "ack0_timeout", 0, 1);
        if (cl) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_clk_en"},    int'(bus.clk_en),    1);
        check({tag, "_div_ratio"}, int'(bus.div_ratio), 1);
        check({tag, "_ack0"},      int'(bus.ack0),      0);
        check({tag, "_ack1"},      int'(bus.ack1),      0);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_owner"},     int'(bus.owner),     0);
    endtask

    task automatic next_idle(input string tag);
        @(negedge clk);
        check(tag, int'(bus.busy), 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && (bus.ack0 || bus.ack1)) begin
            check("ack_both", int'(bus.ack0 && bus.ack1), 0);
            if (sb.size() == 0) begin
                check("unexpected_ack_cycle", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                check("ack_client", int'(bus.ack1), int'(mon_e.cl));
                check("ack_cycle",  cyc, mon_e.cyc);
                check("ack_ratio",  int'(bus.div_ratio), mon_e.ratio);
                check("ack_owner",  int'(bus.owner), int'(mon_e.cl));
                check("ack_clk_en", int'(bus.clk_en), 1);
                check("ack_busy",   int'(bus.busy), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        bus.req0 = 1'b0; bus.ratio0 = '0;
        bus.req1 = 1'b0; bus.ratio1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset("por");

        // Clamp + shortcut: ratio 0 -> 1 equals current, ack next cycle.
        @(negedge clk);
        c = cyc;
        drive(1, 1, 0); push(1, c + 1, 1);
        en_low_seen = 1'b0;
        wait_ack(1, 40);
        check("shortcut_clk_en_high", int'(en_low_seen), 0);

        // req1 ratio 7 from ratio 1: ack at 4+2+14.
        next_idle("idle_b");
        c = cyc;
        drive(1, 1, 7); push(1, c + 20, 7);
        wait_ack(1, 60);

        // req0 ratio 8: clk_en low 1..5, ratio 8 from 6, ack at 22.
        next_idle("idle_c");
        c = cyc;
        drive(0, 1, 8); push(0, c + 22, 8);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check("single_clk_en", int'(bus.clk_en), (k <= 5) ? 0 : 1);
            if (k == 5) check("single_ratio_c5", int'(bus.div_ratio), 7);
            if (k == 6) check("single_ratio_c6", int'(bus.div_ratio), 8);
        end
        bus.req0 = 1'b0;

        // Reset pulse: arbiter back to favouring client 0.
        next_idle("idle_rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("pulse");

        // Contention 4 / 9: client 0 first (ack 14), client 1 granted at 15.
        c = cyc;
        drive(0, 1, 4); drive(1, 1, 9);
        push(0, c + 14, 4); push(1, c + 15 + 24, 9);
        wait_ack(0, 40);
        wait_ack(1, 60);

        // Hold/abandon: req1 raised then dropped during client 0's SETTLE.
        next_idle("idle_e1");
        c = cyc;
        drive(0, 1, 6); push(0, c + 18, 6);
        repeat (3) @(negedge clk);
        drive(1, 1, 5);
        repeat (7) @(negedge clk);
        check("abandon_in_settle_clk_en", int'(bus.clk_en), 1);
        drive(1, 0, 5);
        wait_ack(0, 40);
        repeat (3) @(negedge clk);
        check("abandon_back_idle", int'(bus.busy), 0);

        // Drop req0 during DRAIN: ack still pulses.
        next_idle("idle_e2");
        c = cyc;
        drive(0, 1, 3); push(0, c + 12, 3);
        repeat (2) @(negedge clk);
        drive(0, 0, 3);
        wait_ack(0, 40);

        // Contention again with client 0 granted last: client 1 first.
        next_idle("idle_d2");
        c = cyc;
        drive(0, 1, 4); drive(1, 1, 9);
        push(1, c + 24, 9); push(0, c + 25 + 14, 4);
        wait_ack(1, 60);
        wait_ack(0, 60);

        // Reset during SETTLE with ratio 9: no ack, then a clean retry.
        next_idle("idle_f");
        c = cyc;
        drive(0, 1, 9);
        repeat (10) @(negedge clk);
        check("mid_settle_busy",  int'(bus.busy), 1);
        check("mid_settle_ratio", int'(bus.div_ratio), 9);
        #2 rst = 1'b1;
        #1 chk_reset("mid_settle_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = cyc;
        push(0, c + 24, 9);
        wait_ack(0, 60);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
